uart_rx_buffer: RTL and testbench
=================================

Name: uart_rx_buffer

Overview:
Receive-side byte buffer that sits directly downstream of the UART receiver. It converts the receiver's level-style rx_done indication into exactly one write per received frame. Each byte is stored together with its parity-error flag in a first-word-fall-through FIFO and presented to the host or register interface over a valid/ready handshake. It drives rx_full back to the receiver and keeps sticky overflow status plus saturating drop and error counters.

Parameters:
DEPTH, 16, FIFO entries; power of two, minimum 2
DATA_WIDTH, 8, byte width; matches the receiver's rx_data
DROP_ERRORED, 0, 1 = bytes received with rx_error=1 are discarded rather than stored
CNT_W, 8, width of drop_cnt and err_cnt

Ports:
clk  in  1  system clock
rst  in  1  reset; one clock; reset is synchronous and active-low
rx_data  in  DATA_WIDTH  byte from the receiver
rx_done  in  1  receiver in stop-bit state; level, may stay high for many cycles
rx_error  in  1  parity error for the current byte; valid while rx_done=1
rx_full  out  1  FIFO full, fed back to the receiver
out_data  out  DATA_WIDTH  head-of-FIFO byte
out_error  out  1  error flag stored with the head byte
out_valid  out  1  FIFO not empty
out_ready  in  1  consumer accepts the head entry
level  out  $clog2(DEPTH)+1  current entry count, 0..DEPTH
overflow  out  1  sticky: at least one byte was dropped because the FIFO was full
drop_cnt  out  CNT_W  bytes dropped due to full, saturating
err_cnt  out  CNT_W  bytes received with rx_error=1, saturating, whether stored or not
flush  in  1  synchronous FIFO clear
stat_clr  in  1  clears overflow, drop_cnt and err_cnt

Behaviour:
- Reset (rst=0 at a clk edge):
  - rd_ptr, wr_ptr and level = 0.
  - out_valid=0, rx_full=0, overflow=0, drop_cnt=0, err_cnt=0.
  - out_data and out_error are don't-care while out_valid=0.
  - done_d resets to 1, so an rx_done held high across reset release does not capture a stale byte.
- Capture:
  - done_d <= rx_done every cycle.
  - cap = rx_done & ~done_d, i.e. one capture per rising edge of rx_done.
  - rx_data and rx_error are sampled in the cap cycle only.
- Pop: pop = out_valid & out_ready.
- Write conditions, all evaluated in the cap cycle:
  - wr_en = cap & ~(DROP_ERRORED & rx_error) & (level<DEPTH | pop).
  - When full, a capture coinciding with a pop is accepted and level stays DEPTH.
  - cap & full & ~pop, with the byte otherwise storable: byte dropped, overflow<=1, drop_cnt +1 (saturating at all-ones).
  - cap & rx_error: err_cnt +1 (saturating), independent of whether the byte is stored.
  - cap & rx_error & DROP_ERRORED=1: nothing written, no overflow or drop counted even when full.
- FIFO:
  - Storage is {rx_error, rx_data} per entry.
  - Pointers wrap modulo DEPTH.
  - level: +1 on write only, -1 on pop only, unchanged on both or neither.
- Outputs:
  - out_valid = (level!=0); out_data/out_error = mem[rd_ptr], combinational read.
  - Latency: a byte captured at edge N is visible with out_valid=1 after edge N.
  - A byte is never readable in the same cycle it is written.
  - rx_full = (level==DEPTH), registered-equivalent (derived from level).
- Handshake:
  - out_data and out_error hold stable while out_valid=1 and out_ready=0.
  - out_ready while empty has no effect.
- flush:
  - Highest priority for FIFO state: pointers and level are set to 0, and any same-cycle write or pop is discarded.
  - Counters and overflow are not affected.
  - done_d still updates, so an rx_done already high does not re-capture after flush.
- stat_clr:
  - Clears overflow and both counters.
  - If a drop or error event occurs in the same cycle, the counter loads 1 and overflow loads 1 as applicable (the event wins over the clear).
- Reset mid-frame or while holding data: all state is cleared per the reset rule; no partial or duplicate write follows.

Test Plan:
- Single byte: rx_data=0xA5 with rx_done high for 5 cycles, out_ready=0 -> exactly one entry; level=1; out_valid=1 one cycle after the capture edge; out_data=0xA5, out_error=0. Then out_ready=1 for 1 cycle -> level=0, out_valid=0.
- Fill and overflow, DEPTH=16: 17 frames 0x00..0x10, out_ready=0 -> rx_full=1 after frame 16; frame 0x10 dropped; overflow=1, drop_cnt=1. Drain -> 0x00..0x0F in order. stat_clr -> overflow=0, drop_cnt=0.
- Full with simultaneous pop: FIFO full and out_ready=1 in the capture cycle of 0x77 -> no drop; level stays 16; 0x77 is last out.
- Parity errors: DROP_ERRORED=0, frames 0x11 (err=1) and 0x22 (err=0) -> both stored with out_error 1 then 0; err_cnt=1. With DROP_ERRORED=1 -> only 0x22 stored; err_cnt=1; drop_cnt=0.
- Reset/flush: rx_done held high through rst release -> no entry written. flush with level=5 and a same-cycle capture -> level=0, nothing written, counters unchanged.
- Wrap-around: 40 bytes streamed with out_ready toggling every other cycle -> all 40 read in order; level never exceeds DEPTH; drop_cnt=0.

Source files
------------

// File: rtl/uart_rx_buffer_if.sv
// Consumer-side valid/ready handshake of the UART receive buffer.
// The buffer drives the head entry; the host only drives out_ready.
interface uart_rx_buffer_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_error;
  logic                  out_valid;
  logic                  out_ready;

  modport master (output out_data, output out_error, output out_valid, input out_ready);
  modport slave  (input out_data, input out_error, input out_valid, output out_ready);
endinterface

// File: rtl/uart_rx_buffer.sv
// Receive-side FWFT byte buffer behind the UART receiver: edge-captures rx_done,
// stores {rx_error, rx_data}, and keeps sticky overflow plus saturating drop/error counters.
module uart_rx_buffer #(
  parameter int DEPTH        = 16,
  parameter int DATA_WIDTH   = 8,
  parameter int DROP_ERRORED = 0,
  parameter int CNT_W        = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_WIDTH-1:0]   rx_data,
  input  logic                    rx_done,
  input  logic                    rx_error,
  output logic                    rx_full,
  uart_rx_buffer_if.master        out_if,
  output logic [$clog2(DEPTH):0]  level,
  output logic                    overflow,
  output logic [CNT_W-1:0]        drop_cnt,
  output logic [CNT_W-1:0]        err_cnt,
  input  logic                    flush,
  input  logic                    stat_clr
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [DATA_WIDTH:0] mem_q [DEPTH];

  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             done_q, done_d;
  logic             overflow_q, overflow_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

  logic cap, full, pop, storable, wr_en, drop_ev, err_ev;

  // A full FIFO still accepts a capture when the head leaves in the same cycle.
  always_comb begin
    cap      = rx_done & ~done_q;
    full     = (level_q == LW'(DEPTH));
    pop      = (level_q != '0) & out_if.out_ready;
    storable = cap & ~((DROP_ERRORED != 0) & rx_error);
    wr_en    = storable & (~full | pop) & ~flush;
    drop_ev  = storable & full & ~pop;
    err_ev   = cap & rx_error;
  end

  always_comb begin
    done_d   = rx_done;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    level_d  = level_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)   rd_ptr_d = rd_ptr_q + AW'(1);
      case ({wr_en, pop})
        2'b10:   level_d = level_q + LW'(1);
        2'b01:   level_d = level_q - LW'(1);
        default: level_d = level_q;
      endcase
    end
  end

  // The clear is applied first so an event in the same cycle lands on top of it.
  always_comb begin
    overflow_d = overflow_q & ~stat_clr;
    drop_cnt_d = stat_clr ? '0 : drop_cnt_q;
    err_cnt_d  = stat_clr ? '0 : err_cnt_q;
    if (drop_ev) begin
      overflow_d = 1'b1;
      if (drop_cnt_d != '1) drop_cnt_d = drop_cnt_d + CNT_W'(1);
    end
    if (err_ev) begin
      if (err_cnt_d != '1) err_cnt_d = err_cnt_d + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      done_q     <= 1'b1;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
      err_cnt_q  <= '0;
    end else begin
      done_q     <= done_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst && wr_en) mem_q[wr_ptr_q] <= {rx_error, rx_data};
  end

  assign out_if.out_valid                    = (level_q != '0);
  assign {out_if.out_error, out_if.out_data} = mem_q[rd_ptr_q];
  assign rx_full                             = full;
  assign level                               = level_q;
  assign overflow                            = overflow_q;
  assign drop_cnt                            = drop_cnt_q;
  assign err_cnt                             = err_cnt_q;

endmodule

// File: tb/tb_uart_rx_buffer.sv
// Self-checking bench: two buffers (keep / drop errored bytes) fed the same frames,
// compared every cycle against a queue-level reference model plus hand-written sequences.
module tb_uart_rx_buffer;

  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_done, rx_error, flush, stat_clr, out_ready;

  logic       d_full [2];
  logic       d_ovf [2];
  logic [4:0] d_level [2];
  logic [7:0] d_drop [2];
  logic [7:0] d_err [2];
  logic       d_valid [2];
  logic [7:0] d_data [2];
  logic       d_derr [2];

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;
  int max_lvl  = 0;

  uart_rx_buffer_if #(.DATA_WIDTH(8)) if0 ();
  uart_rx_buffer_if #(.DATA_WIDTH(8)) if1 ();

  assign if0.out_ready = out_ready;
  assign if1.out_ready = out_ready;

  uart_rx_buffer #(.DEPTH(DEPTH), .DATA_WIDTH(8), .DROP_ERRORED(0), .CNT_W(8)) u0 (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_done(rx_done), .rx_error(rx_error),
    .rx_full(d_full[0]), .out_if(if0), .level(d_level[0]), .overflow(d_ovf[0]),
    .drop_cnt(d_drop[0]), .err_cnt(d_err[0]), .flush(flush), .stat_clr(stat_clr)
  );

  uart_rx_buffer #(.DEPTH(DEPTH), .DATA_WIDTH(8), .DROP_ERRORED(1), .CNT_W(8)) u1 (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_done(rx_done), .rx_error(rx_error),
    .rx_full(d_full[1]), .out_if(if1), .level(d_level[1]), .overflow(d_ovf[1]),
    .drop_cnt(d_drop[1]), .err_cnt(d_err[1]), .flush(flush), .stat_clr(stat_clr)
  );

  assign d_valid[0] = if0.out_valid;
  assign d_data[0]  = if0.out_data;
  assign d_derr[0]  = if0.out_error;
  assign d_valid[1] = if1.out_valid;
  assign d_data[1]  = if1.out_data;
  assign d_derr[1]  = if1.out_error;

  always #5 clk = ~clk;

  // Reference model: a circular list of {error, byte} per instance, counted in plain integers.
  logic [8:0] m_buf [2][DEPTH];
  int         m_head [2] = '{0, 0};
  int         m_cnt [2]  = '{0, 0};
  int         m_drop [2] = '{0, 0};
  int         m_err [2]  = '{0, 0};
  bit         m_ovf [2]  = '{0, 0};
  bit         m_prev [2] = '{1, 1};

  task automatic modelStep(input int k, input bit drop_mode);
    bit rising, popped, accepted, dropped;
    if (!rst) begin
      m_head[k] = 0; m_cnt[k] = 0; m_drop[k] = 0; m_err[k] = 0;
      m_ovf[k] = 1'b0; m_prev[k] = 1'b1;
      return;
    end
    rising    = rx_done && !m_prev[k];
    m_prev[k] = rx_done;
    popped    = (m_cnt[k] > 0) && out_ready;
    accepted  = 1'b0;
    dropped   = 1'b0;
    if (rising && !(drop_mode && rx_error)) begin
      if (m_cnt[k] < DEPTH || popped) accepted = 1'b1;
      else dropped = 1'b1;
    end
    if (stat_clr) begin
      m_ovf[k] = 1'b0; m_drop[k] = 0; m_err[k] = 0;
    end
    if (dropped) begin
      m_ovf[k] = 1'b1;
      if (m_drop[k] < 255) m_drop[k]++;
    end
    if (rising && rx_error && m_err[k] < 255) m_err[k]++;
    if (flush) begin
      m_head[k] = 0; m_cnt[k] = 0;
    end else begin
      if (popped) begin
        m_head[k] = (m_head[k] + 1) % DEPTH;
        m_cnt[k]--;
      end
      if (accepted) begin
        m_buf[k][(m_head[k] + m_cnt[k]) % DEPTH] = {rx_error, rx_data};
        m_cnt[k]++;
      end
    end
  endtask

  always @(posedge clk) begin
    modelStep(0, 1'b0);
    modelStep(1, 1'b1);
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelCompare(input int k);
    string p;
    p = $sformatf("u%0d.", k);
    checkOutput({p, "level"}, 32'(d_level[k]), 32'(m_cnt[k]));
    checkOutput({p, "out_valid"}, 32'(d_valid[k]), 32'(m_cnt[k] > 0));
    checkOutput({p, "rx_full"}, 32'(d_full[k]), 32'(m_cnt[k] == DEPTH));
    checkOutput({p, "overflow"}, 32'(d_ovf[k]), 32'(m_ovf[k]));
    checkOutput({p, "drop_cnt"}, 32'(d_drop[k]), 32'(m_drop[k]));
    checkOutput({p, "err_cnt"}, 32'(d_err[k]), 32'(m_err[k]));
    if (m_cnt[k] > 0) begin
      checkOutput({p, "out_data"}, 32'(d_data[k]), 32'(m_buf[k][m_head[k]][7:0]));
      checkOutput({p, "out_error"}, 32'(d_derr[k]), 32'(m_buf[k][m_head[k]][8]));
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      modelCompare(0);
      modelCompare(1);
      if (int'(d_level[0]) > max_lvl) max_lvl = int'(d_level[0]);
    end
  end

  // One frame: rx_done held for 'hold' edges, then low for one edge so the next frame re-arms.
  task automatic applyStimulus(input logic [7:0] data, input logic err, input int hold);
    rx_data  = data;
    rx_error = err;
    rx_done  = 1'b1;
    repeat (hold) @(negedge clk);
    rx_done  = 1'b0;
    rx_error = 1'b0;
    @(negedge clk);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       err;
    int         exp_lvl0;
    int         exp_lvl1;
    int         exp_err;
  } vec_t;

  vec_t vecs [2];
  bit   stream_done;
  int   n_err_sent;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vecs[0] = '{data: 8'h11, err: 1'b1, exp_lvl0: 1, exp_lvl1: 0, exp_err: 1};
    vecs[1] = '{data: 8'h22, err: 1'b0, exp_lvl0: 2, exp_lvl1: 1, exp_err: 1};

    rst = 1'b0; rx_data = '0; rx_done = 1'b0; rx_error = 1'b0;
    flush = 1'b0; stat_clr = 1'b0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    for (int k = 0; k < 2; k++) begin
      checkOutput("reset.level", 32'(d_level[k]), 32'd0);
      checkOutput("reset.out_valid", 32'(d_valid[k]), 32'd0);
      checkOutput("reset.rx_full", 32'(d_full[k]), 32'd0);
      checkOutput("reset.overflow", 32'(d_ovf[k]), 32'd0);
      checkOutput("reset.drop_cnt", 32'(d_drop[k]), 32'd0);
      checkOutput("reset.err_cnt", 32'(d_err[k]), 32'd0);
    end
    rst = 1'b1;
    @(negedge clk);

    $display("[TB] single byte with long rx_done");
    rx_data = 8'hA5; rx_done = 1'b1;
    @(negedge clk);
    checkOutput("single.valid_latency", 32'(d_valid[0]), 32'd1);
    repeat (4) @(negedge clk);
    rx_done = 1'b0;
    @(negedge clk);
    checkOutput("single.level", 32'(d_level[0]), 32'd1);
    checkOutput("single.data", 32'(d_data[0]), 32'hA5);
    checkOutput("single.error", 32'(d_derr[0]), 32'd0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checkOutput("single.level_after_pop", 32'(d_level[0]), 32'd0);
    checkOutput("single.valid_after_pop", 32'(d_valid[0]), 32'd0);

    $display("[TB] fill and overflow");
    for (int i = 0; i < 17; i++) begin
      applyStimulus(8'(i), 1'b0, 2);
      if (i == 15) checkOutput("fill.rx_full", 32'(d_full[0]), 32'd1);
    end
    checkOutput("fill.level", 32'(d_level[0]), 32'd16);
    checkOutput("fill.overflow", 32'(d_ovf[0]), 32'd1);
    checkOutput("fill.drop_cnt", 32'(d_drop[0]), 32'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      checkOutput("drain.order", 32'(d_data[0]), 32'(i));
      @(negedge clk);
    end
    out_ready = 1'b0;
    checkOutput("drain.level", 32'(d_level[0]), 32'd0);
    stat_clr = 1'b1;
    @(negedge clk);
    stat_clr = 1'b0;
    checkOutput("stat_clr.overflow", 32'(d_ovf[0]), 32'd0);
    checkOutput("stat_clr.drop_cnt", 32'(d_drop[0]), 32'd0);

    $display("[TB] full with simultaneous pop");
    for (int i = 0; i < 16; i++) applyStimulus(8'(8'h30 + i), 1'b0, 1);
    rx_data = 8'h77; rx_done = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    rx_done = 1'b0; out_ready = 1'b0;
    checkOutput("fullpop.level", 32'(d_level[0]), 32'd16);
    checkOutput("fullpop.drop_cnt", 32'(d_drop[0]), 32'd0);
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      checkOutput("fullpop.order", 32'(d_data[0]), (i < 15) ? 32'(8'h31 + i) : 32'h77);
      @(negedge clk);
    end
    out_ready = 1'b0;

    $display("[TB] parity error vectors");
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].data, vecs[i].err, 2);
      checkOutput("parity.level_keep", 32'(d_level[0]), 32'(vecs[i].exp_lvl0));
      checkOutput("parity.level_drop", 32'(d_level[1]), 32'(vecs[i].exp_lvl1));
      checkOutput("parity.err_cnt_keep", 32'(d_err[0]), 32'(vecs[i].exp_err));
      checkOutput("parity.err_cnt_drop", 32'(d_err[1]), 32'(vecs[i].exp_err));
    end
    checkOutput("parity.head_keep", 32'(d_data[0]), 32'h11);
    checkOutput("parity.head_keep_err", 32'(d_derr[0]), 32'd1);
    checkOutput("parity.head_drop", 32'(d_data[1]), 32'h22);
    checkOutput("parity.head_drop_err", 32'(d_derr[1]), 32'd0);
    checkOutput("parity.drop_cnt_drop", 32'(d_drop[1]), 32'd0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checkOutput("parity.second_keep", 32'(d_data[0]), 32'h22);
    checkOutput("parity.second_keep_err", 32'(d_derr[0]), 32'd0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;

    $display("[TB] rx_done held through reset");
    rst = 1'b0; rx_data = 8'hEE; rx_done = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("rstheld.level_keep", 32'(d_level[0]), 32'd0);
    checkOutput("rstheld.level_drop", 32'(d_level[1]), 32'd0);
    rx_done = 1'b0;
    @(negedge clk);

    $display("[TB] flush with same-cycle capture");
    for (int i = 0; i < 5; i++) applyStimulus(8'(8'h40 + i), 1'b0, 1);
    checkOutput("flush.level_before", 32'(d_level[0]), 32'd5);
    rx_data = 8'h5A; rx_done = 1'b1; flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checkOutput("flush.level", 32'(d_level[0]), 32'd0);
    checkOutput("flush.valid", 32'(d_valid[0]), 32'd0);
    checkOutput("flush.err_cnt", 32'(d_err[0]), 32'd0);
    checkOutput("flush.drop_cnt", 32'(d_drop[0]), 32'd0);
    repeat (2) @(negedge clk);
    checkOutput("flush.no_recapture", 32'(d_level[0]), 32'd0);
    rx_done = 1'b0;
    @(negedge clk);

    $display("[TB] random stream with toggling ready");
    stream_done = 1'b0;
    n_err_sent  = 0;
    max_lvl     = 0;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          logic e;
          e = 1'($urandom_range(0, 1));
          if (e) n_err_sent++;
          applyStimulus(8'($urandom), e, int'($urandom_range(1, 3)));
        end
        stream_done = 1'b1;
      end
      begin
        while (!stream_done) begin
          @(negedge clk);
          out_ready = ~out_ready;
        end
      end
    join
    out_ready = 1'b1;
    repeat (20) @(negedge clk);
    out_ready = 1'b0;
    checkOutput("stream.level_keep", 32'(d_level[0]), 32'd0);
    checkOutput("stream.level_drop", 32'(d_level[1]), 32'd0);
    checkOutput("stream.drop_cnt_keep", 32'(d_drop[0]), 32'd0);
    checkOutput("stream.drop_cnt_drop", 32'(d_drop[1]), 32'd0);
    checkOutput("stream.err_cnt_keep", 32'(d_err[0]), 32'(n_err_sent));
    checkOutput("stream.err_cnt_drop", 32'(d_err[1]), 32'(n_err_sent));
    checkOutput("stream.max_level_bound", 32'(max_lvl <= DEPTH), 32'd1);

    @(negedge clk);
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
